vpi_scan_responder: RTL and testbench

- Hardware-side responder for the one-to-many VPI iteration protocol (vpi_iterate / vpi_scan / vpi_free_object).
- Holds a loadable object table of {type, parent handle} entries.
- Serves iterate, scan and free requests over a valid/ready request channel and a valid/ready response channel.
- Sits under the DPI shim so C-side iteration of on-chip objects is serviced by RTL rather than the simulator.

---
 rtl/vpi_scan_responder.sv | 209 ++++++++++++++++++++
 tb/tb_vpi_scan_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vpi_scan_responder.sv
// Hardware responder for VPI iterate/scan/free over an on-chip object table.
// Optional statistics outputs are enabled by defining VPI_SCAN_STATS_EN.
module vpi_scan_responder #(
    parameter int NUM_OBJS  = 16,
    parameter int NUM_ITERS = 4,
    parameter int HANDLE_W  = 8,
    parameter int TYPE_W    = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tbl_we,
    input  logic [$clog2(NUM_OBJS)-1:0]  tbl_idx,
    input  logic [TYPE_W-1:0]            tbl_type,
    input  logic [HANDLE_W-1:0]          tbl_parent,
    output logic                         tbl_busy,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [HANDLE_W-1:0]          req_handle,
    input  logic [TYPE_W-1:0]            req_type,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [HANDLE_W-1:0]          rsp_handle,
    output logic                         rsp_err
`ifdef VPI_SCAN_STATS_EN
    ,
    output logic [$clog2(NUM_ITERS+1)-1:0] stat_active,
    output logic [15:0]                    stat_alloc_fail
`endif
);
    localparam int IDX_W  = $clog2(NUM_OBJS);
    localparam int POS_W  = $clog2(NUM_OBJS + 1);
    localparam int SLOT_W = (NUM_ITERS > 1) ? $clog2(NUM_ITERS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [1:0] OP_ITER = 2'd0;
    localparam logic [1:0] OP_SCAN = 2'd1;
    localparam logic [1:0] OP_FREE = 2'd2;

    logic [1:0]          state;
    logic [TYPE_W-1:0]   obj_type   [NUM_OBJS];
    logic [HANDLE_W-1:0] obj_parent [NUM_OBJS];
    logic [NUM_ITERS-1:0] it_active;
    logic [TYPE_W-1:0]   it_type    [NUM_ITERS];
    logic [HANDLE_W-1:0] it_parent  [NUM_ITERS];
    logic [POS_W-1:0]    it_pos     [NUM_ITERS];
    logic                op_iter;
    logic [SLOT_W-1:0]   cur_slot;
    logic [IDX_W-1:0]    cur_idx;

    logic                free_found;
    logic [SLOT_W-1:0]   free_slot;
    logic                handle_ok;
    logic [SLOT_W-1:0]   req_slot;
    logic                slot_live;
    logic                hit;
    logic                last;

    // Handshakes: a request transfers on a clock edge with req_valid && req_ready,
    // a response on rsp_valid && rsp_ready; rsp_valid and its payload hold until taken.
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign tbl_busy  = (state != ST_IDLE);

    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int s = NUM_ITERS - 1; s >= 0; s--) begin
            if (!it_active[s]) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(s);
            end
        end
    end

    assign handle_ok = (req_handle != '0) && (req_handle <= HANDLE_W'(NUM_ITERS));
    assign req_slot  = SLOT_W'(req_handle - HANDLE_W'(1));
    assign slot_live = handle_ok && it_active[req_slot];

    assign hit  = (obj_type[cur_idx] != '0) &&
                  (obj_type[cur_idx] == it_type[cur_slot]) &&
                  (obj_parent[cur_idx] == it_parent[cur_slot]);
    assign last = (cur_idx == IDX_W'(NUM_OBJS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_iter    <= 1'b0;
            cur_slot   <= '0;
            cur_idx    <= '0;
            rsp_handle <= '0;
            rsp_err    <= 1'b0;
            it_active  <= '0;
            for (int i = 0; i < NUM_OBJS; i++) begin
                obj_type[i]   <= '0;
                obj_parent[i] <= '0;
            end
            for (int s = 0; s < NUM_ITERS; s++) begin
                it_type[s]   <= '0;
                it_parent[s] <= '0;
                it_pos[s]    <= '0;
            end
        end else begin
            // The table is only writable between operations so a search sees a stable view.
            if (tbl_we && state == ST_IDLE) begin
                obj_type[tbl_idx]   <= tbl_type;
                obj_parent[tbl_idx] <= tbl_parent;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        rsp_handle <= '0;
                        rsp_err    <= 1'b0;
                        op_iter    <= (req_op == OP_ITER);
                        case (req_op)
                            OP_ITER: begin
                                if (free_found) begin
                                    it_active[free_slot] <= 1'b1;
                                    it_type[free_slot]   <= req_type;
                                    it_parent[free_slot] <= req_handle;
                                    it_pos[free_slot]    <= '0;
                                    cur_slot             <= free_slot;
                                    cur_idx              <= '0;
                                    state                <= ST_SEARCH;
                                end else begin
                                    rsp_err <= 1'b1;
                                    state   <= ST_RESP;
                                end
                            end
                            OP_SCAN: begin
                                if (!slot_live) begin
                                    rsp_err <= 1'b1;
                                    state   <= ST_RESP;
                                end else if (it_pos[req_slot] == POS_W'(NUM_OBJS)) begin
                                    // Already past the last entry: exhausted, auto-free.
                                    it_active[req_slot] <= 1'b0;
                                    state               <= ST_RESP;
                                end else begin
                                    cur_slot <= req_slot;
                                    cur_idx  <= IDX_W'(it_pos[req_slot]);
                                    state    <= ST_SEARCH;
                                end
                            end
                            OP_FREE: begin
                                if (slot_live) begin
                                    it_active[req_slot] <= 1'b0;
                                end else begin
                                    rsp_err <= 1'b1;
                                end
                                state <= ST_RESP;
                            end
                            default: begin
                                rsp_err <= 1'b1;
                                state   <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_SEARCH: begin
                    if (hit) begin
                        state <= ST_RESP;
                        if (op_iter) begin
                            rsp_handle       <= HANDLE_W'(cur_slot) + HANDLE_W'(1);
                            it_pos[cur_slot] <= POS_W'(cur_idx);
                        end else begin
                            rsp_handle       <= HANDLE_W'(cur_idx) + HANDLE_W'(1);
                            it_pos[cur_slot] <= POS_W'(cur_idx) + POS_W'(1);
                        end
                    end else if (last) begin
                        it_active[cur_slot] <= 1'b0;
                        state               <= ST_RESP;
                    end else begin
                        cur_idx <= cur_idx + IDX_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state      <= ST_IDLE;
                        rsp_handle <= '0;
                        rsp_err    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef VPI_SCAN_STATS_EN
    always_comb begin
        stat_active = '0;
        for (int s = 0; s < NUM_ITERS; s++) begin
            stat_active = stat_active + ($clog2(NUM_ITERS+1))'(it_active[s]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_alloc_fail <= '0;
        end else if (state == ST_IDLE && req_valid && req_op == OP_ITER &&
                     !free_found && stat_alloc_fail != 16'hFFFF) begin
            stat_alloc_fail <= stat_alloc_fail + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vpi_scan_responder.sv
// Directed self-checking bench for vpi_scan_responder with an expected-response queue.
module tb_vpi_scan_responder;
    localparam int NOBJ = 16;
    localparam int NITER = 4;

    logic        clk;
    logic        rst_n;
    logic        tbl_we;
    logic [3:0]  tbl_idx;
    logic [9:0]  tbl_type;
    logic [7:0]  tbl_parent;
    logic        tbl_busy;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_handle;
    logic [9:0]  req_type;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_handle;
    logic        rsp_err;
`ifdef VPI_SCAN_STATS_EN
    logic [2:0]  stat_active;
    logic [15:0] stat_alloc_fail;
`endif

    logic [8:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    vpi_scan_responder #(
        .NUM_OBJS(NOBJ), .NUM_ITERS(NITER), .HANDLE_W(8), .TYPE_W(10)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_type(tbl_type),
        .tbl_parent(tbl_parent), .tbl_busy(tbl_busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_handle(req_handle), .req_type(req_type),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_handle(rsp_handle), .rsp_err(rsp_err)
`ifdef VPI_SCAN_STATS_EN
        , .stat_active(stat_active), .stat_alloc_fail(stat_alloc_fail)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tbl_write(input logic [3:0] idx, input logic [9:0] t, input logic [7:0] p);
        tbl_we = 1'b1; tbl_idx = idx; tbl_type = t; tbl_parent = p;
        @(posedge clk);
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    // Issue one request, push its expected response, then wait for and score the response.
    // lat: cycles from accept edge to rsp_valid (0 = unchecked); hold: cycles rsp_ready stays low.
    task automatic do_req(input logic [1:0] op, input logic [7:0] h, input logic [9:0] t,
                          input logic [7:0] eh, input logic ee, input int lat, input int hold);
        int n;
        logic [8:0] exp;
        exp_q.push_back({ee, eh});
        req_op = op; req_handle = h; req_type = t; req_valid = 1'b1;
        check("req_ready_idle", 32'(req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        tbl_we = 1'b0;
        n = 1;
        while (!rsp_valid && n < NOBJ + 4) begin
            @(negedge clk);
            n++;
        end
        exp = exp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 1);
        if (lat > 0) check("latency", n, lat);
        check("rsp_handle", 32'(rsp_handle), 32'(exp[7:0]));
        check("rsp_err", 32'(rsp_err), 32'(exp[8]));
        for (int i = 0; i < hold; i++) begin
            tbl_we = 1'b1; tbl_idx = 4'd5; tbl_type = 10'd0; tbl_parent = 8'd0;
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_handle", 32'(rsp_handle), 32'(exp[7:0]));
            check("hold_req_ready", 32'(req_ready), 0);
            check("hold_busy", 32'(tbl_busy), 1);
        end
        tbl_we = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_type = '0; tbl_parent = '0;
        req_valid = 1'b0; req_op = '0; req_handle = '0; req_type = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_handle", 32'(rsp_handle), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_tbl_busy", 32'(tbl_busy), 0);
        check("rst_req_ready", 32'(req_ready), 1);
`ifdef VPI_SCAN_STATS_EN
        check("rst_stat_active", 32'(stat_active), 0);
        check("rst_stat_fail", 32'(stat_alloc_fail), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Empty table: null iterator after a full sweep, slot released
        do_req(2'd0, 8'd1, 10'd36, 8'd0, 1'b0, NOBJ + 1, 0);
        do_req(2'd2, 8'd1, 10'd0, 8'd0, 1'b1, 1, 0);

        // Iterate and scan to exhaustion, with distractor entries
        tbl_write(4'd2, 10'd36, 8'd1);
        tbl_write(4'd5, 10'd36, 8'd1);
        tbl_write(4'd9, 10'd36, 8'd1);
        tbl_write(4'd3, 10'd36, 8'd2);
        tbl_write(4'd4, 10'd37, 8'd1);
        do_req(2'd0, 8'd1, 10'd36, 8'd1, 1'b0, 4, 0);
        do_req(2'd1, 8'd1, 10'd0, 8'd3, 1'b0, 2, 0);
        do_req(2'd1, 8'd1, 10'd0, 8'd6, 1'b0, 4, 0);
        do_req(2'd1, 8'd1, 10'd0, 8'd10, 1'b0, 5, 0);
        do_req(2'd1, 8'd1, 10'd0, 8'd0, 1'b0, 7, 0);
        do_req(2'd1, 8'd1, 10'd0, 8'd0, 1'b1, 1, 0);

        // Slot exhaustion, free and reallocation
        do_req(2'd0, 8'd1, 10'd36, 8'd1, 1'b0, 4, 0);
        do_req(2'd0, 8'd1, 10'd36, 8'd2, 1'b0, 4, 0);
        do_req(2'd0, 8'd1, 10'd36, 8'd3, 1'b0, 4, 0);
        do_req(2'd0, 8'd1, 10'd36, 8'd4, 1'b0, 4, 0);
        do_req(2'd0, 8'd1, 10'd36, 8'd0, 1'b1, 1, 0);
`ifdef VPI_SCAN_STATS_EN
        check("stat_active_full", 32'(stat_active), 4);
        check("stat_alloc_fail", 32'(stat_alloc_fail), 1);
`endif
        do_req(2'd2, 8'd2, 10'd0, 8'd0, 1'b0, 1, 0);
        do_req(2'd0, 8'd1, 10'd36, 8'd2, 1'b0, 4, 0);
        do_req(2'd2, 8'd0, 10'd0, 8'd0, 1'b1, 1, 0);
        do_req(2'd2, 8'd5, 10'd0, 8'd0, 1'b1, 1, 0);
        do_req(2'd1, 8'd5, 10'd0, 8'd0, 1'b1, 1, 0);
        do_req(2'd3, 8'd1, 10'd36, 8'd0, 1'b1, 1, 0);
        for (int s = 1; s <= NITER; s++) do_req(2'd2, 8'(s), 10'd0, 8'd0, 1'b0, 1, 0);
        do_req(2'd2, 8'd3, 10'd0, 8'd0, 1'b1, 1, 0);

        // Top-level parent 0, best-case latency
        tbl_write(4'd0, 10'd5, 8'd0);
        do_req(2'd0, 8'd0, 10'd5, 8'd1, 1'b0, 2, 0);
        do_req(2'd2, 8'd1, 10'd0, 8'd0, 1'b0, 1, 0);

        // Table write in the accept cycle is visible to the search (match at last index)
        tbl_we = 1'b1; tbl_idx = 4'd15; tbl_type = 10'd7; tbl_parent = 8'd3;
        do_req(2'd0, 8'd3, 10'd7, 8'd1, 1'b0, NOBJ + 1, 0);
        do_req(2'd2, 8'd1, 10'd0, 8'd0, 1'b0, 1, 0);

        // Backpressure: response held, writes to idx 5 ignored while busy
        do_req(2'd0, 8'd1, 10'd36, 8'd1, 1'b0, 4, 5);
        do_req(2'd1, 8'd1, 10'd0, 8'd3, 1'b0, 2, 0);
        do_req(2'd1, 8'd1, 10'd0, 8'd6, 1'b0, 4, 0);
        do_req(2'd2, 8'd1, 10'd0, 8'd0, 1'b0, 1, 0);

        // Reset during SEARCH abandons the scan and clears iterators and table
        do_req(2'd0, 8'd1, 10'd36, 8'd1, 1'b0, 4, 0);
        req_op = 2'd1; req_handle = 8'd1; req_type = 10'd0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("search_busy", 32'(tbl_busy), 1);
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 0);
        check("arst_rsp_handle", 32'(rsp_handle), 0);
        check("arst_tbl_busy", 32'(tbl_busy), 0);
        check("arst_req_ready", 32'(req_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        check("no_rsp_after_reset", seen, 0);
        do_req(2'd1, 8'd1, 10'd0, 8'd0, 1'b1, 1, 0);
        do_req(2'd0, 8'd1, 10'd36, 8'd0, 1'b0, NOBJ + 1, 0);
`ifdef VPI_SCAN_STATS_EN
        check("stat_active_end", 32'(stat_active), 0);
        check("stat_fail_end", 32'(stat_alloc_fail), 0);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
